// File: rtl/priority_arbiter_pkg.sv
// priority_arbiter_pkg: shared sizing helper for the priority arbiter
package priority_arbiter_pkg;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/priority_arbiter_core.sv
// priority_arbiter_core: combinational lowest-index-wins grant, valid and binary index
module priority_arbiter_core
   import priority_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   localparam int IDX_W = idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] requests_i,
   output logic [NUM_PORTS-1:0] grants_o,
   output logic                 grant_valid_o,
   output logic [IDX_W-1:0]     grant_idx_o
);
   always_comb begin
      grants_o = requests_i & (~requests_i + NUM_PORTS'(1));
      grant_valid_o = |requests_i;
      grant_idx_o = '0;
      // grants_o is one-hot, so OR-ing the indices of set bits yields the encoded index
      for (int i = 0; i < NUM_PORTS; i++)
         grant_idx_o = grant_idx_o | (grants_o[i] ? IDX_W'(i) : '0);
   end
endmodule

// File: rtl/priority_arbiter.sv
// priority_arbiter: registered fixed-priority arbiter, bit 0 highest priority
module priority_arbiter
   import priority_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   localparam int IDX_W = idx_width(NUM_PORTS)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [NUM_PORTS-1:0] requests_i,
   output logic [NUM_PORTS-1:0] grants_o,
   output logic                 grant_valid_o,
   output logic [IDX_W-1:0]     grant_idx_o
);
   logic [NUM_PORTS-1:0] core_grants, grants_d, grants_q;
   logic                 core_valid, valid_d, valid_q;
   logic [IDX_W-1:0]     core_idx, idx_d, idx_q;
   priority_arbiter_core #(.NUM_PORTS(NUM_PORTS)) u_core (
      .requests_i    (requests_i),
      .grants_o      (core_grants),
      .grant_valid_o (core_valid),
      .grant_idx_o   (core_idx)
   );
   always_comb begin
      grants_d = core_grants;
      valid_d = core_valid;
      idx_d = core_idx;
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         grants_q <= '0;
         valid_q <= 1'b0;
         idx_q <= '0;
      end else begin
         grants_q <= grants_d;
         valid_q <= valid_d;
         idx_q <= idx_d;
      end
   end
   assign grants_o = grants_q;
   assign grant_valid_o = valid_q;
   assign grant_idx_o = idx_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: vector table plus scoreboarded random sweep for priority_arbiter
module tb_priority_arbiter;
   localparam int N = 4;
   typedef struct packed {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] grant;
      logic         valid;
      logic [1:0]   idx;
   } vec_t;
   logic         clk = 1'b0;
   logic         reset_i = 1'b0;
   logic [N-1:0] requests_i = '0;
   logic [N-1:0] grants_o;
   logic         grant_valid_o;
   logic [1:0]   grant_idx_o;
   int           checks = 0;
   int           errors = 0;
   vec_t         sb[$];
   vec_t         tbl[11];
   priority_arbiter #(.NUM_PORTS(N)) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .requests_i    (requests_i),
      .grants_o      (grants_o),
      .grant_valid_o (grant_valid_o),
      .grant_idx_o   (grant_idx_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic vec_t model(input logic rst, input logic [N-1:0] req);
      vec_t v;
      v = '{rst: rst, req: req, grant: '0, valid: 1'b0, idx: 2'd0};
      if (!rst)
         for (int i = N - 1; i >= 0; i--)
            if (req[i]) begin
               v.grant = N'(1) << i;
               v.valid = 1'b1;
               v.idx = 2'(i);
            end
      return v;
   endfunction
   task automatic step(input vec_t v, input bit inv);
      vec_t e;
      logic [N-1:0] prev;
      reset_i = v.rst;
      requests_i = v.req;
      prev = v.req;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("grants", int'(grants_o), int'(e.grant));
      chk("valid", int'(grant_valid_o), int'(e.valid));
      chk("idx", int'(grant_idx_o), int'(e.idx));
      if (inv) begin
         chk("onehot_or_zero", int'($countones(grants_o) <= 1), 1);
         chk("valid_eq_or", int'(grant_valid_o == |grants_o), 1);
         chk("subset_prev_req", int'((grants_o & ~prev) == '0), 1);
         if (grant_valid_o) chk("idx_consistent", int'(grants_o[grant_idx_o]), 1);
      end
   endtask
   initial begin
      tbl[0]  = '{rst: 1'b1, req: 4'b1111, grant: 4'b0000, valid: 1'b0, idx: 2'd0};
      tbl[1]  = '{rst: 1'b1, req: 4'b1111, grant: 4'b0000, valid: 1'b0, idx: 2'd0};
      tbl[2]  = '{rst: 1'b0, req: 4'b0101, grant: 4'b0001, valid: 1'b1, idx: 2'd0};
      tbl[3]  = '{rst: 1'b0, req: 4'b1010, grant: 4'b0010, valid: 1'b1, idx: 2'd1};
      tbl[4]  = '{rst: 1'b0, req: 4'b0001, grant: 4'b0001, valid: 1'b1, idx: 2'd0};
      tbl[5]  = '{rst: 1'b0, req: 4'b1110, grant: 4'b0010, valid: 1'b1, idx: 2'd1};
      tbl[6]  = '{rst: 1'b0, req: 4'b1000, grant: 4'b1000, valid: 1'b1, idx: 2'd3};
      tbl[7]  = '{rst: 1'b0, req: 4'b0111, grant: 4'b0001, valid: 1'b1, idx: 2'd0};
      tbl[8]  = '{rst: 1'b0, req: 4'b0000, grant: 4'b0000, valid: 1'b0, idx: 2'd0};
      tbl[9]  = '{rst: 1'b1, req: 4'b1100, grant: 4'b0000, valid: 1'b0, idx: 2'd0};
      tbl[10] = '{rst: 1'b0, req: 4'b1100, grant: 4'b0100, valid: 1'b1, idx: 2'd2};
      @(posedge clk);
      #1;
      foreach (tbl[k]) step(tbl[k], 1'b0);
      step('{rst: 1'b0, req: 4'b1111, grant: 4'b0001, valid: 1'b1, idx: 2'd0}, 1'b1);
      step('{rst: 1'b1, req: 4'b1000, grant: 4'b0000, valid: 1'b0, idx: 2'd0}, 1'b1);
      step('{rst: 1'b0, req: 4'b1000, grant: 4'b1000, valid: 1'b1, idx: 2'd3}, 1'b1);
      for (int c = 0; c < 200; c++) step(model(1'b0, N'($urandom_range(0, 15))), 1'b1);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
